ch_est_frame_ctrl: RTL
======================

Name: ch_est_frame_ctrl

Overview:
- Frame scheduler placed directly upstream of the channel estimator/equalizer in the 802.16 RX chain.
- Receives the FFT output stream (one 32-bit {Im,Re} sample per Wishbone write) and counts subcarriers and symbols against a per-frame configuration.
- Forwards samples through a one-entry registered stage, tagged with preamble flag, subcarrier index and symbol index.
- Frames the downstream CYC_O so the estimator sees exactly (NSYM+1)·NFFT samples per frame: symbol 0 is the preamble, then NSYM data symbols.

Parameters:
NFFT, 256, samples per OFDM symbol after CP removal (power of 2, 64 or 256)
SC_W, 8, width of subcarrier index, log2(NFFT)
SYM_W, 8, width of symbol counter / NSYM_I

Ports:
CLK_I  in  1  system clock, all logic on rising edge
RST_I  in  1  reset, asynchronous, active-low
DAT_I  in  32  upstream sample {Im[31:16], Re[15:0]}
CYC_I  in  1  upstream frame cycle; rising edge starts a frame
STB_I  in  1  upstream strobe
WE_I  in  1  upstream write enable
ACK_O  out  1  upstream acknowledge
NSYM_I  in  SYM_W  data symbols per frame; sampled on frame start
DAT_O  out  32  registered sample
CYC_O  out  1  downstream frame cycle
STB_O  out  1  downstream strobe (output valid)
WE_O  out  1  downstream write enable, equal to STB_O
ACK_I  in  1  downstream acknowledge
PRE_O  out  1  current DAT_O belongs to symbol 0 (preamble)
SC_IDX_O  out  SC_W  subcarrier index of DAT_O
SYM_IDX_O  out  SYM_W  symbol index of DAT_O
FRM_ERR_O  out  1  one-cycle pulse on truncated frame or overrun

Behaviour:
- Reset (RST_I=0, asynchronous): DAT_O=0, CYC_O=0, STB_O=0, WE_O=0, PRE_O=0, SC_IDX_O=0, SYM_IDX_O=0, FRM_ERR_O=0. ACK_O stays 0 while RST_I=0. The FSM enters IDLE, all counters are 0, and the output register is emptied. Reset mid-frame discards everything; no partial flush.
- Upstream transfer: xfer_in = CYC_I & STB_I & WE_I & ACK_O.
- Downstream transfer: xfer_out = STB_O & ACK_I.
- ACK_O = ~STB_O | ACK_I in PRE/DATA, and 1 in FLUSH. This is combinational and gives full throughput with a one-entry pipeline.
- Latency: a sample accepted at edge k appears on DAT_O after edge k (valid in cycle k+1). Simultaneous xfer_in and xfer_out replace the register contents with no bubble.
- FSM states:
  - IDLE: on CYC_I=1, latch nsym=NSYM_I, clear counters, assert CYC_O, go to PRE.
  - PRE: accepts NFFT samples tagged PRE=1, sym=0. The last accepted sample (sc=NFFT-1) moves to DATA, or to DRAIN if nsym=0.
  - DATA: sc counts 0..NFFT-1 and wraps, incrementing sym. Acceptance of sc=NFFT-1 with sym=nsym moves to DRAIN.
  - DRAIN: ACK_O=0 for new data. When the register is empty (STB_O=0 or xfer_out), drop CYC_O. Then go to FLUSH if CYC_I=1, else to IDLE.
  - FLUSH: ACK_O=1, and accepted samples are discarded. The first discarded sample pulses FRM_ERR_O (overrun). Exit to IDLE when CYC_I=0.
- Truncation: CYC_I falls in PRE/DATA before the frame completes → FRM_ERR_O pulses once, go to DRAIN. Samples already held are delivered; no padding.
- CYC_I must be low for at least one cycle between frames. A new frame cannot start until IDLE.
- Tags (PRE_O, SC_IDX_O, SYM_IDX_O) are registered alongside DAT_O and change only when a new sample is loaded.
- Counters never exceed NFFT-1 / nsym. SYM_IDX_O is reported modulo 2^SYM_W.

Optional Feature:
- Macro: CH_EST_FRM_STAT_EN.
- Defined:
  - Adds output FRM_CNT_O[15:0], a count of completed, untruncated frames. It increments on the DRAIN→IDLE/FLUSH exit when no truncation occurred, wraps at 0xFFFF, and resets to 0.
  - Adds output ERR_CNT_O[7:0], a count of FRM_ERR_O pulses. It saturates at 0xFF and resets to 0.
- Not defined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- NFFT=256, NSYM_I=9, ACK_I=1, continuous 2560-sample burst → 2560 outputs in order with 1-cycle latency. PRE_O=1 for outputs 0..255. SYM_IDX_O runs 0..9 and SC_IDX_O wraps 255→0. CYC_O falls after output 2559. FRM_ERR_O stays 0.
- Same burst, ACK_I toggling 1,0 each cycle → no sample lost or duplicated, ACK_O=0 exactly when STB_O=1 and ACK_I=0, and the output sequence is identical to the first case.
- NSYM_I=2, upstream sends 800 samples → 768 forwarded. FRM_ERR_O pulses on sample 768. Samples 768..799 are acked and discarded, then the FSM returns to IDLE after CYC_I falls.
- NSYM_I=9, CYC_I drops after 300 samples → 300 forwarded (last tag sym=1, sc=43), FRM_ERR_O pulses once, CYC_O falls after the last output, and the next frame starts cleanly at sym=0, sc=0.
- Assert RST_I=0 at sample 1000 of a frame → all outputs 0 within the same cycle (async). After release, a new 2560-sample frame is forwarded correctly.
- With CH_EST_FRM_STAT_EN: run 3 good frames and 1 truncated frame → FRM_CNT_O=3 and ERR_CNT_O=1.

Source files
------------

// File: rtl/ch_est_frame_ctrl_if.sv
// rtl/ch_est_frame_ctrl_if.sv - upstream/downstream bus bundle for ch_est_frame_ctrl (CH_EST_FRM_STAT_EN adds stats)
interface ch_est_frame_ctrl_if #(
  parameter int SC_W  = 8,
  parameter int SYM_W = 8
);
  logic [31:0]      DAT_I;
  logic             CYC_I;
  logic             STB_I;
  logic             WE_I;
  logic             ACK_O;
  logic [SYM_W-1:0] NSYM_I;
  logic [31:0]      DAT_O;
  logic             CYC_O;
  logic             STB_O;
  logic             WE_O;
  logic             ACK_I;
  logic             PRE_O;
  logic [SC_W-1:0]  SC_IDX_O;
  logic [SYM_W-1:0] SYM_IDX_O;
  logic             FRM_ERR_O;
`ifdef CH_EST_FRM_STAT_EN
  logic [15:0]      FRM_CNT_O;
  logic [7:0]       ERR_CNT_O;
`endif

  modport slave (
`ifdef CH_EST_FRM_STAT_EN
    output FRM_CNT_O, output ERR_CNT_O,
`endif
    input  DAT_I, input CYC_I, input STB_I, input WE_I, input NSYM_I, input ACK_I,
    output ACK_O, output DAT_O, output CYC_O, output STB_O, output WE_O,
    output PRE_O, output SC_IDX_O, output SYM_IDX_O, output FRM_ERR_O
  );

  modport master (
`ifdef CH_EST_FRM_STAT_EN
    input  FRM_CNT_O, input ERR_CNT_O,
`endif
    output DAT_I, output CYC_I, output STB_I, output WE_I, output NSYM_I, output ACK_I,
    input  ACK_O, input DAT_O, input CYC_O, input STB_O, input WE_O,
    input  PRE_O, input SC_IDX_O, input SYM_IDX_O, input FRM_ERR_O
  );
endinterface

// File: rtl/ch_est_frame_ctrl.sv
// rtl/ch_est_frame_ctrl.sv - frame scheduler ahead of the channel estimator; CH_EST_FRM_STAT_EN adds frame/error counters
module ch_est_frame_ctrl #(
  parameter int NFFT  = 256,
  parameter int SC_W  = 8,
  parameter int SYM_W = 8
) (
  input logic               CLK_I,
  input logic               RST_I,
  ch_est_frame_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PRE, DATA, DRAIN, FLUSH} state_e;

  localparam logic [SC_W-1:0] SC_LAST = SC_W'(NFFT - 1);

  state_e           state_q;
  logic [SC_W-1:0]  sc_q;
  logic [SYM_W-1:0] sym_q;
  logic [SYM_W-1:0] nsym_q;
  logic [31:0]      dat_q;
  logic             stb_q;
  logic             cyc_q;
  logic             pre_q;
  logic [SC_W-1:0]  sc_idx_q;
  logic [SYM_W-1:0] sym_idx_q;
  logic             err_q;
  logic             flushed_q;
`ifdef CH_EST_FRM_STAT_EN
  logic             trunc_q;
  logic [15:0]      frm_cnt_q;
  logic [7:0]       err_cnt_q;
`endif

  logic ack;
  logic xfer_in;
  logic xfer_out;
  logic empty;
  logic fwd;

  always_comb begin
    ack = 1'b0;
    case (state_q)
      PRE, DATA: ack = ~stb_q | bus.ACK_I;
      FLUSH:     ack = 1'b1;
      default:   ack = 1'b0;
    endcase
  end

  assign xfer_in  = bus.CYC_I & bus.STB_I & bus.WE_I & ack;
  assign xfer_out = stb_q & bus.ACK_I;
  assign empty    = ~stb_q | xfer_out;
  assign fwd      = xfer_in & ((state_q == PRE) | (state_q == DATA));

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q   <= IDLE;
      sc_q      <= '0;
      sym_q     <= '0;
      nsym_q    <= '0;
      dat_q     <= '0;
      stb_q     <= 1'b0;
      cyc_q     <= 1'b0;
      pre_q     <= 1'b0;
      sc_idx_q  <= '0;
      sym_idx_q <= '0;
      err_q     <= 1'b0;
      flushed_q <= 1'b0;
`ifdef CH_EST_FRM_STAT_EN
      trunc_q   <= 1'b0;
      frm_cnt_q <= '0;
      err_cnt_q <= '0;
`endif
    end else begin
      err_q <= 1'b0;

      // Output stage: a load wins over a drain so back-to-back transfers leave no bubble.
      if (fwd) begin
        dat_q     <= bus.DAT_I;
        stb_q     <= 1'b1;
        pre_q     <= (state_q == PRE);
        sc_idx_q  <= sc_q;
        sym_idx_q <= sym_q;
      end else if (xfer_out) begin
        stb_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (bus.CYC_I) begin
            nsym_q    <= bus.NSYM_I;
            sc_q      <= '0;
            sym_q     <= '0;
            cyc_q     <= 1'b1;
            state_q   <= PRE;
`ifdef CH_EST_FRM_STAT_EN
            trunc_q   <= 1'b0;
`endif
          end
        end

        PRE, DATA: begin
          if (!bus.CYC_I) begin
            err_q   <= 1'b1;
            state_q <= DRAIN;
`ifdef CH_EST_FRM_STAT_EN
            trunc_q <= 1'b1;
`endif
          end else if (xfer_in) begin
            if (sc_q == SC_LAST) begin
              sc_q <= '0;
              // sym_q is 0 during the preamble, so nsym=0 ends the frame right after it.
              if (sym_q == nsym_q) begin
                state_q <= DRAIN;
              end else begin
                sym_q   <= sym_q + SYM_W'(1);
                state_q <= DATA;
              end
            end else begin
              sc_q <= sc_q + SC_W'(1);
            end
          end
        end

        DRAIN: begin
          if (empty) begin
            cyc_q     <= 1'b0;
            flushed_q <= 1'b0;
            state_q   <= bus.CYC_I ? FLUSH : IDLE;
`ifdef CH_EST_FRM_STAT_EN
            if (!trunc_q) frm_cnt_q <= frm_cnt_q + 16'd1;
`endif
          end
        end

        FLUSH: begin
          if (xfer_in && !flushed_q) begin
            err_q     <= 1'b1;
            flushed_q <= 1'b1;
          end
          if (!bus.CYC_I) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase

`ifdef CH_EST_FRM_STAT_EN
      if (err_q && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
`endif
    end
  end

  assign bus.ACK_O     = ack;
  assign bus.DAT_O     = dat_q;
  assign bus.CYC_O     = cyc_q;
  assign bus.STB_O     = stb_q;
  assign bus.WE_O      = stb_q;
  assign bus.PRE_O     = pre_q;
  assign bus.SC_IDX_O  = sc_idx_q;
  assign bus.SYM_IDX_O = sym_idx_q;
  assign bus.FRM_ERR_O = err_q;
`ifdef CH_EST_FRM_STAT_EN
  assign bus.FRM_CNT_O = frm_cnt_q;
  assign bus.ERR_CNT_O = err_cnt_q;
`endif
endmodule
